// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared constants, types and helpers for the DMA master
//
// Holds the FSM state encoding, the burst length and the address/size widths.
// Build option: DMAC_BURST4_EN selects 4-word bursts with a 4-entry buffer.
// Without it the engine moves one word at a time with a 1-entry buffer.
package dmac_pkg;

  localparam int ADDR_W = 16;
  localparam int SIZE_W = 12;
  // Wide enough to hold a beat index 0..BURST and a chunk length 1..BURST.
  localparam int CNT_W  = 3;

`ifdef DMAC_BURST4_EN
  localparam int BURST = 4;
`else
  localparam int BURST = 1;
`endif

  localparam int BUF_IDX_W = (BURST > 1) ? $clog2(BURST) : 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SIZE_W-1:0] size_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POP   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic addr_t cnt_to_addr(input cnt_t c);
    return {{(ADDR_W-CNT_W){1'b0}}, c};
  endfunction

  function automatic size_t cnt_to_size(input cnt_t c);
    return {{(SIZE_W-CNT_W){1'b0}}, c};
  endfunction

  // Words moved by the next read/write pair: min(remaining, BURST).
  function automatic cnt_t chunk_of(input size_t rem);
    if (rem < SIZE_W'(BURST)) begin
      return rem[CNT_W-1:0];
    end
    return CNT_W'(BURST);
  endfunction

endpackage

// File: rtl/dmac_burst_buf.sv
// rtl/dmac_burst_buf.sv - index-addressed word buffer holding one burst
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset (clears contents)
//   wr_en/wr_idx/wr_data  write one slot per cycle
//   rd_idx/rd_data     combinational read; out-of-range index returns 0
module dmac_burst_buf #(
  parameter int DEPTH  = 1,
  parameter int IDX_W  = 1,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Slots are matched by compare rather than direct indexing so a
  // single-entry buffer needs no zero-width index.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/dmac_master.sv
// rtl/dmac_master.sv - descriptor-driven memory-to-memory DMA bus master
//
// Pops {src, dst, size} descriptors and copies size words from src to dst in
// bursts: BURST reads into a local buffer, then BURST writes from it.
// Build option: DMAC_BURST4_EN (see dmac_pkg) selects BURST=4, else BURST=1.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   m_begin / m_end     start level in, all-descriptors-finished level out
//   empty / rd_en       descriptor FIFO status in, one-cycle pop strobe out
//   src_addr, dst_addr, data_size  popped descriptor, valid cycle after rd_en
//   m_req, m_wr, m_addr, m_dout    bus request, direction, address, write data
//   m_grant, m_din                 bus completion strobe, read data
module dmac_master
  import dmac_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m_begin,
  output logic        m_end,
  input  logic        empty,
  output logic        rd_en,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [31:0] data_size,
  output logic        m_req,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [31:0] m_dout,
  input  logic        m_grant,
  input  logic [31:0] m_din
);

  logic [2:0]  state_q, state_d;
  logic        rd_en_q, rd_en_d;
  logic        m_end_q, m_end_d;
  logic        m_req_q, m_req_d;
  logic        m_wr_q, m_wr_d;
  addr_t       m_addr_q, m_addr_d;
  logic [31:0] m_dout_q, m_dout_d;
  addr_t       src_q, src_d;
  addr_t       dst_q, dst_d;
  size_t       rem_q, rem_d;
  cnt_t        chunk_q, chunk_d;
  cnt_t        k_q, k_d;

  cnt_t        k_inc;
  logic        last_beat;
  size_t       rem_after;
  size_t       new_size;

  logic                 buf_wr_en;
  logic [BUF_IDX_W-1:0] buf_wr_idx;
  logic [BUF_IDX_W-1:0] buf_rd_idx;
  logic [31:0]          buf_rd_data;

  // Upper descriptor bits are outside the 16-bit address / 12-bit size space.
  logic unused_desc_bits;
  assign unused_desc_bits = ^{src_addr[31:16], dst_addr[31:16], data_size[31:12]};

  assign k_inc      = k_q + 1'b1;
  assign last_beat  = (k_inc == chunk_q);
  assign rem_after  = rem_q - cnt_to_size(chunk_q);
  assign new_size   = data_size[SIZE_W-1:0];

  assign buf_wr_idx = k_q[BUF_IDX_W-1:0];
  // While a write beat is outstanding the next beat's data is prefetched so
  // m_dout can advance in the same cycle as the grant.
  assign buf_rd_idx = ((state_q == ST_WRITE) && m_req_q) ? k_inc[BUF_IDX_W-1:0]
                                                         : k_q[BUF_IDX_W-1:0];

  dmac_burst_buf #(
    .DEPTH  (BURST),
    .IDX_W  (BUF_IDX_W),
    .DATA_W (32)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (buf_wr_en),
    .wr_idx  (buf_wr_idx),
    .wr_data (m_din),
    .rd_idx  (buf_rd_idx),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    m_end_d   = m_end_q;
    m_req_d   = m_req_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_dout_d  = m_dout_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    chunk_d   = chunk_q;
    k_d       = k_q;
    buf_wr_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m_begin) begin
          if (!empty) begin
            rd_en_d = 1'b1;
            state_d = ST_POP;
          end else begin
            m_end_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_POP: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        src_d = src_addr[ADDR_W-1:0];
        dst_d = dst_addr[ADDR_W-1:0];
        rem_d = new_size;
        k_d   = '0;
        if (new_size == '0) begin
          if (!empty) begin
            rd_en_d = 1'b1;
            state_d = ST_POP;
          end else begin
            m_end_d = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          chunk_d = chunk_of(new_size);
          state_d = ST_READ;
        end
      end

      // Each phase opens with one cycle of m_req low (entry cycle), then
      // keeps m_req high across its beats and drops it after the last grant.
      ST_READ: begin
        if (!m_req_q) begin
          m_req_d  = 1'b1;
          m_wr_d   = 1'b0;
          m_addr_d = src_q + cnt_to_addr(k_q);
        end else if (m_grant) begin
          buf_wr_en = 1'b1;
          if (last_beat) begin
            m_req_d = 1'b0;
            k_d     = '0;
            state_d = ST_WRITE;
          end else begin
            k_d      = k_inc;
            m_addr_d = src_q + cnt_to_addr(k_inc);
          end
        end
      end

      ST_WRITE: begin
        if (!m_req_q) begin
          m_req_d  = 1'b1;
          m_wr_d   = 1'b1;
          m_addr_d = dst_q + cnt_to_addr(k_q);
          m_dout_d = buf_rd_data;
        end else if (m_grant) begin
          if (last_beat) begin
            m_req_d = 1'b0;
            m_wr_d  = 1'b0;
            k_d     = '0;
            src_d   = src_q + cnt_to_addr(chunk_q);
            dst_d   = dst_q + cnt_to_addr(chunk_q);
            rem_d   = rem_after;
            if (rem_after != '0) begin
              chunk_d = chunk_of(rem_after);
              state_d = ST_READ;
            end else if (!empty) begin
              rd_en_d = 1'b1;
              state_d = ST_POP;
            end else begin
              m_end_d = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            k_d      = k_inc;
            m_addr_d = dst_q + cnt_to_addr(k_inc);
            m_dout_d = buf_rd_data;
          end
        end
      end

      ST_DONE: begin
        if (!m_begin) begin
          m_end_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        m_end_d = 1'b0;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rd_en_q  <= 1'b0;
      m_end_q  <= 1'b0;
      m_req_q  <= 1'b0;
      m_wr_q   <= 1'b0;
      m_addr_q <= '0;
      m_dout_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      chunk_q  <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      rd_en_q  <= rd_en_d;
      m_end_q  <= m_end_d;
      m_req_q  <= m_req_d;
      m_wr_q   <= m_wr_d;
      m_addr_q <= m_addr_d;
      m_dout_q <= m_dout_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      chunk_q  <= chunk_d;
      k_q      <= k_d;
    end
  end

  assign rd_en  = rd_en_q;
  assign m_end  = m_end_q;
  assign m_req  = m_req_q;
  assign m_wr   = m_wr_q;
  assign m_addr = m_addr_q;
  assign m_dout = m_dout_q;

endmodule

// File: tb/tb_dmac_master.sv
// tb/tb_dmac_master.sv - self-checking bench for dmac_master
module tb_dmac_master;

`ifdef DMAC_BURST4_EN
  localparam int BM = 4;
`else
  localparam int BM = 1;
`endif

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [11:0] size;
  } desc_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } tx_t;

  logic        clk;
  logic        reset_n;
  logic        m_begin;
  logic        m_end;
  logic        empty;
  logic        rd_en;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] data_size;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_dout;
  logic        m_grant;
  logic [31:0] m_din;

  dmac_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m_begin   (m_begin),
    .m_end     (m_end),
    .empty     (empty),
    .rd_en     (rd_en),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .data_size (data_size),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_dout    (m_dout),
    .m_grant   (m_grant),
    .m_din     (m_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  desc_t fifo_q[$];
  desc_t run_list[$];
  tx_t   obs_q[$];
  tx_t   exp_q[$];
  int    pops;
  int    stall_max;
  bit    stall_rand;
  int    stall_tgt;
  logic [31:0] seed;

  function automatic logic [31:0] mem_word(input logic [15:0] a, input logic [31:0] s);
    return {a, ~a} ^ s;
  endfunction

  // Bus slave, descriptor FIFO and transaction recorder, all acting on the
  // falling edge so the DUT sees stable inputs at the rising edge.
  initial begin : responder
    desc_t       d;
    logic [31:0] tmp;
    logic [31:0] din;
    bit          pend;
    logic [15:0] pend_addr;
    logic        pend_wr;
    int          stall_cnt;
    m_grant = 1'b0; m_din = '0; src_addr = '0; dst_addr = '0; data_size = '0;
    empty = 1'b1; pend = 1'b0; stall_cnt = 0; pend_addr = '0; pend_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_grant = 1'b0; pend = 1'b0; stall_cnt = 0;
      end else begin
        if (rd_en) begin
          pops++;
          if (fifo_q.size() > 0) begin
            d = fifo_q.pop_front();
            tmp = $urandom();
            src_addr  = {tmp[31:16], d.src};
            dst_addr  = {tmp[15:0], d.dst};
            data_size = {tmp[19:0], d.size};
          end
        end
        empty = (fifo_q.size() == 0);
        if (m_end) begin
          checks++;
          if (m_req !== 1'b0) begin
            errors++;
            $display("FAIL req_in_done: m_req=%0b required 0", m_req);
          end
        end
        if (m_req) begin
          if (pend) begin
            checks++;
            if (m_addr !== pend_addr || m_wr !== pend_wr) begin
              errors++;
              $display("FAIL stall_stable: addr=%h wr=%0b required addr=%h wr=%0b",
                       m_addr, m_wr, pend_addr, pend_wr);
            end
          end
          if (stall_cnt < stall_tgt) begin
            stall_cnt++;
            m_grant = 1'b0; pend = 1'b1; pend_addr = m_addr; pend_wr = m_wr;
            m_din = $urandom();
          end else begin
            m_grant = 1'b1; pend = 1'b0; stall_cnt = 0;
            stall_tgt = stall_rand ? int'($urandom_range(stall_max, 0)) : stall_max;
            din = m_wr ? m_dout : mem_word(m_addr, seed);
            m_din = m_wr ? $urandom() : din;
            obs_q.push_back({m_wr, m_addr, din});
          end
        end else begin
          m_grant = 1'b0; pend = 1'b0; m_din = $urandom();
        end
      end
    end
  end

  task automatic set_stall(input int mx, input bit rnd);
    stall_max  = mx;
    stall_rand = rnd;
    stall_tgt  = mx;
  endtask

  // Reference: every descriptor is cut into min(rem,BM) pieces; each piece is
  // all its reads in address order, then all its writes with the read data.
  task automatic build_expected();
    logic [15:0] s, dd;
    int rem, c;
    exp_q.delete();
    foreach (run_list[i]) begin
      s = run_list[i].src; dd = run_list[i].dst; rem = int'(run_list[i].size);
      while (rem > 0) begin
        c = (rem < BM) ? rem : BM;
        for (int j = 0; j < c; j++) exp_q.push_back({1'b0, 16'(s + 16'(j)), mem_word(16'(s + 16'(j)), seed)});
        for (int j = 0; j < c; j++) exp_q.push_back({1'b1, 16'(dd + 16'(j)), mem_word(16'(s + 16'(j)), seed)});
        s = 16'(s + 16'(c)); dd = 16'(dd + 16'(c)); rem -= c;
      end
    end
  endtask

  function automatic int count_writes();
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i].wr) n++;
    return n;
  endfunction

  task automatic run_and_check(input string name, input bit drop_begin);
    bit seen;
    int n;
    obs_q.delete();
    pops = 0;
    seed = $urandom();
    build_expected();
    foreach (run_list[i]) fifo_q.push_back(run_list[i]);
    @(negedge clk);
    m_begin = 1'b1;
    seen = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (drop_begin && obs_q.size() > 0) m_begin = 1'b0;
      if (m_end) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s m_end_timeout: m_end=%0b required 1", name, m_end);
    end
    m_begin = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s tx_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s tx[%0d]: got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h",
                 name, i, obs_q[i].wr, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (pops != run_list.size()) begin
      errors++;
      $display("FAIL %s pops: got %0d required %0d", name, pops, run_list.size());
    end
    @(negedge clk);
    checks++;
    if (m_end !== 1'b0) begin
      errors++;
      $display("FAIL %s m_end_clear: got %0b required 0", name, m_end);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_begin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_end, rd_en, m_req, m_wr, m_addr, m_dout} !== 52'd0) begin
      errors++;
      $display("FAIL reset_outputs: end=%0b rd_en=%0b req=%0b wr=%0b addr=%h dout=%h required all 0",
               m_end, rd_en, m_req, m_wr, m_addr, m_dout);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    set_stall(0, 0);
    run_list.delete();
    run_list.push_back('{src: 16'h0010, dst: 16'h0100, size: 12'd6});
    run_and_check("single", 0);
    checks++;
    if (count_writes() != 6) begin
      errors++;
      $display("FAIL single_writes: got %0d required 6", count_writes());
    end
  endtask

  task automatic test_two_desc();
    set_stall(0, 0);
    run_list.delete();
    run_list.push_back('{src: 16'($urandom()), dst: 16'($urandom()), size: 12'd2});
    run_list.push_back('{src: 16'($urandom()), dst: 16'($urandom()), size: 12'd5});
    run_and_check("two_desc", 0);
    checks++;
    if (count_writes() != 7 || pops != 2) begin
      errors++;
      $display("FAIL two_desc_totals: writes=%0d pops=%0d required writes=7 pops=2", count_writes(), pops);
    end
  endtask

  task automatic test_zero_size();
    set_stall(0, 0);
    run_list.delete();
    run_list.push_back('{src: 16'h1234, dst: 16'h4321, size: 12'd0});
    run_list.push_back('{src: 16'h0200, dst: 16'h0300, size: 12'd1});
    run_and_check("zero_size", 0);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL zero_size_bus: got %0d transfers required 2", obs_q.size());
    end
  endtask

  task automatic test_wrap_stall();
    logic [15:0] want [4];
    int r;
    want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000; want[3] = 16'h0001;
    set_stall(3, 0);
    run_list.delete();
    run_list.push_back('{src: 16'hFFFE, dst: 16'($urandom()), size: 12'd4});
    run_and_check("wrap_stall", 0);
    r = 0;
    foreach (obs_q[i]) begin
      if (!obs_q[i].wr && r < 4) begin
        checks++;
        if (obs_q[i].addr !== want[r]) begin
          errors++;
          $display("FAIL wrap_read_addr[%0d]: got %h required %h", r, obs_q[i].addr, want[r]);
        end
        r++;
      end
    end
    checks++;
    if (r != 4) begin
      errors++;
      $display("FAIL wrap_read_count: got %0d required 4", r);
    end
    set_stall(0, 0);
  endtask

  task automatic test_empty_begin();
    pops = 0;
    fifo_q.delete();
    @(negedge clk);
    checks++;
    if (m_end !== 1'b0) begin
      errors++;
      $display("FAIL empty_pre: m_end=%0b required 0", m_end);
    end
    m_begin = 1'b1;
    @(negedge clk);
    checks++;
    if (m_end !== 1'b1 || pops != 0) begin
      errors++;
      $display("FAIL empty_done: m_end=%0b pops=%0d required m_end=1 pops=0", m_end, pops);
    end
    m_begin = 1'b0;
    @(negedge clk);
    checks++;
    if (m_end !== 1'b0) begin
      errors++;
      $display("FAIL empty_clear: m_end=%0b required 0", m_end);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_begin_drop();
    set_stall(1, 1);
    run_list.delete();
    run_list.push_back('{src: 16'($urandom()), dst: 16'($urandom()), size: 12'd7});
    run_list.push_back('{src: 16'($urandom()), dst: 16'($urandom()), size: 12'd3});
    run_and_check("begin_drop", 1);
    set_stall(0, 0);
  endtask

  task automatic test_random();
    int n;
    logic [15:0] s;
    for (int it = 0; it < 8; it++) begin
      set_stall(2, 1);
      run_list.delete();
      n = int'($urandom_range(3, 1));
      for (int j = 0; j < n; j++) begin
        s = ($urandom_range(1, 0) == 1) ? 16'(16'hFFF8 + 16'($urandom_range(7, 0))) : 16'($urandom());
        run_list.push_back('{src: s, dst: 16'($urandom()), size: 12'($urandom_range(9, 0))});
      end
      run_and_check($sformatf("random%0d", it), 0);
    end
    set_stall(0, 0);
  endtask

  task automatic test_reset_mid_write();
    bit hit;
    set_stall(1, 0);
    run_list.delete();
    fifo_q.push_back('{src: 16'h0400, dst: 16'h0800, size: 12'd8});
    @(negedge clk);
    m_begin = 1'b1;
    hit = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (m_req && m_wr) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midreset_reach_write: never saw a write request");
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({m_end, rd_en, m_req, m_wr, m_addr, m_dout} !== 52'd0) begin
      errors++;
      $display("FAIL midreset_outputs: end=%0b rd_en=%0b req=%0b wr=%0b addr=%h dout=%h required all 0",
               m_end, rd_en, m_req, m_wr, m_addr, m_dout);
    end
    m_begin = 1'b0;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (m_end !== 1'b0 || m_req !== 1'b0 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL midreset_idle[%0d]: end=%0b req=%0b rd_en=%0b required 0 0 0", c, m_end, m_req, rd_en);
      end
    end
    set_stall(0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    m_begin = 1'b0;
    pops = 0;
    seed = '0;
    set_stall(0, 0);
    test_reset();
    test_single();
    test_two_desc();
    test_zero_size();
    test_wrap_stall();
    test_empty_begin();
    test_begin_drop();
    test_random();
    test_reset_mid_write();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmac_master.md
DMAC_MASTER -- requirements
Module: dmac_master

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port m_begin  input  1  start level from register slave; held high until m_end observed.
REQ-004 SHALL have port m_end  output  1  all queued descriptors finished; held until m_begin low.
REQ-005 SHALL have port empty  input  1  descriptor FIFOs empty (the three FIFOs move in lockstep).
REQ-006 SHALL have port rd_en  output  1  one-cycle pop strobe to all three descriptor FIFOs.
REQ-007 SHALL have port src_addr  input  32  popped source word address, valid cycle after rd_en.
REQ-008 SHALL have port dst_addr  input  32  popped destination word address, valid cycle after rd_en.
REQ-009 SHALL have port data_size  input  32  popped transfer length in words; bits [11:0] used.
REQ-010 SHALL have port m_req  output  1  bus request; a transfer completes in a cycle with m_req=1 and m_grant=1.
REQ-011 SHALL have port m_wr  output  1  1=write, 0=read; stable while m_req high.
REQ-012 SHALL have port m_addr  output  16  bus word address.
REQ-013 SHALL have port m_dout  output  32  write data.
REQ-014 SHALL have port m_grant  input  1  bus grant/complete strobe.
REQ-015 SHALL have port m_din  input  32  read data, valid in the m_grant cycle of a read.

Function
REQ-016 SHALL implement FSM states IDLE, POP, LOAD, READ, WRITE, DONE, all registered.
REQ-017 SHALL in IDLE, on m_begin=1 and empty=0, assert rd_en for exactly one cycle and enter POP; m_begin=1 with empty=1 enters DONE.
REQ-018 SHALL in POP (rd_en low) go to LOAD; LOAD captures src[15:0], dst[15:0], rem=data_size[11:0].
REQ-019 SHALL, from LOAD, skip a descriptor with rem=0: go to POP (with rd_en) if empty=0, else DONE.
REQ-020 SHALL set chunk=min(rem,BURST) on READ entry, BURST=4 (see REQ-029).
REQ-021 SHALL in READ drive m_req=1, m_wr=0, m_addr=src+k; on each grant store m_din in buffer slot k, k++; after chunk grants enter WRITE.
REQ-022 SHALL in WRITE drive m_req=1, m_wr=1, m_addr=dst+k, m_dout=buffer[k]; after chunk grants update src+=chunk, dst+=chunk, rem-=chunk.
REQ-023 SHALL after WRITE go to READ if rem!=0; else POP with rd_en if empty=0; else DONE.
REQ-024 SHALL wrap address arithmetic modulo 2^16 (16'hFFFF+1 = 16'h0000).
REQ-025 SHALL drop m_req in the cycle after the last grant of a phase; m_req never asserted in IDLE, POP, LOAD, DONE.
REQ-026 SHALL in DONE hold m_end=1; when m_begin=0, clear m_end next cycle and return to IDLE.
REQ-027 SHALL ignore m_begin falling mid-transfer; the current descriptor and queue always complete.

Reset
REQ-028 SHALL on reset_n=0 immediately force state IDLE, m_end=0, rd_en=0, m_req=0, m_wr=0, m_addr=0, m_dout=0, counters/buffer 0; mid-transfer reset abandons the transfer without m_end.

Configuration
REQ-029 SHALL, with DMAC_BURST4_EN defined, use BURST=4 with a 4-entry buffer; without it BURST=1 (single word read-then-write, 1-entry buffer), all else identical.

Structure
REQ-030 SHALL place state encoding, BURST constant, and address/size widths in package dmac_pkg.
REQ-031 SHALL implement the data buffer as sub-module dmac_burst_buf (write-by-index, read-by-index, depth BURST).

Verification
REQ-032 SHALL test single descriptor src=0x0010,dst=0x0100,size=6, grant always 1 -> reads 0x10-0x13, writes 0x100-0x103, then 0x14-0x15 / 0x104-0x105, data matches, m_end=1.
REQ-033 SHALL test two queued descriptors (size 2, size 5) -> two rd_en pulses, 7 writes total, single m_end after both.
REQ-034 SHALL test size=0 descriptor followed by size=1 -> no bus cycle for first, one read/write for second.
REQ-035 SHALL test src=0xFFFE,size=4 with grant stalled 3 cycles per access -> addresses 0xFFFE,0xFFFF,0x0000,0x0001; m_req/m_addr stable during stall.
REQ-036 SHALL test m_begin with empty=1 -> no rd_en, m_end=1 next cycle, cleared one cycle after m_begin drops.
REQ-037 SHALL test reset_n pulsed low during WRITE -> all outputs 0 that cycle, IDLE, no m_end.
